axis_pattern_generator: RTL and testbench
=========================================

Name: axis_pattern_generator

Overview:
- Parametrised AXI4-Stream test-pattern source for PFB/FFT datapath benches and on-chip self-test.
- Emits frames of FFT_LEN complex samples, SAMP_PER_CLK samples per beat. Modes: ramp, impulse, constant.
- Fully AXIS-compliant handshake with backpressure, run/stop control, frame counting and tlast.
- Sits at the head of the datapath, in place of the ADC capture, ahead of the polyphase FIR.

Parameters:
- WIDTH, 16, bit width of each re/im component (signed).
- SAMP_PER_CLK, 4, complex samples per beat; power of two, must divide FFT_LEN.
- FFT_LEN, 16, samples per frame; power of two, at least SAMP_PER_CLK.
- IMPULSE_PHA, 0, sample index of the impulse within a frame (0..FFT_LEN-1).
- IMPULSE_VAL, 1, re value of the impulse sample and of constant-mode samples.
- NUM_FRAMES, 0, frames to emit per run; 0 means run continuously until en falls.
- CNT_W, 16, width of frame_cnt.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, run request; level-sensitive.
- mode, in, 2, 0=ramp, 1=impulse, 2=constant, 3=reserved (noise when NOISE_EN, else behaves as 0).
- m_axis_tready, in, 1, downstream ready.
- m_axis_tdata, out, SAMP_PER_CLK*2*WIDTH, packed cx_t array; lane j is sample beat*SAMP_PER_CLK+j; lane 0 is earliest, in the LSBs.
- m_axis_tvalid, out, 1, beat valid.
- m_axis_tlast, out, 1, last beat of frame.
- frame_cnt, out, CNT_W, completed frames since the run started; wraps modulo 2^CNT_W.
- busy, out, 1, high in RUN and STOP.
- done, out, 1, one-cycle pulse after the final frame of a NUM_FRAMES run or a stop completes.

Behaviour:
- Reset (async assert, synchronous deassert by clk): state IDLE, beat=0, tvalid=0, tlast=0, tdata=0, frame_cnt=0, busy=0, done=0, mode_q=0.
- All outputs are registered. Beat counter width is $clog2(FFT_LEN/SAMP_PER_CLK), minimum 1.
- States:
  - IDLE: tvalid=0. en=1 latches mode into mode_q, clears frame_cnt and beat, loads beat 0 data. Next cycle: RUN with tvalid=1.
  - RUN: a beat is held stable while tvalid=1 and tready=0. On handshake (tvalid&tready) beat increments and next beat data loads the same cycle, so full rate is one beat per clock.
  - Handshake with tlast=1:
    - frame_cnt increments; beat wraps to 0; mode is re-latched, so mode changes take effect only at frame boundaries.
    - If NUM_FRAMES!=0 and frame_cnt+1==NUM_FRAMES, go IDLE, tvalid=0, pulse done.
    - Else if en=0, go IDLE, tvalid=0, pulse done.
    - Else continue with beat 0 of the next frame.
  - en falling mid-frame never truncates a frame. The current frame always completes with tlast; STOP is the RUN sub-state tracking a pending stop.
- tlast=1 exactly when beat==FFT_LEN/SAMP_PER_CLK-1. When FFT_LEN==SAMP_PER_CLK, every beat is last.
- Patterns, with im=0 for all modes; n = beat*SAMP_PER_CLK+j:
  - ramp: re = n, truncated to WIDTH bits (wraps).
  - impulse: re = IMPULSE_VAL when n==IMPULSE_PHA, else 0.
  - constant: re = IMPULSE_VAL.
- tvalid never falls without a handshake, except on reset.
- Reset mid-frame: immediate return to reset values. No partial-frame recovery; the next run starts at beat 0.
- en held high through the end of a NUM_FRAMES run: the block stays IDLE for at least one cycle with done=1, then restarts.

Optional Feature:
- Macro PATTERN_NOISE_EN.
- Defined: mode 3 selects a 2*WIDTH-bit Fibonacci LFSR per lane, seeded at run start with lane index+1. Each lane advances once per handshake. re = upper WIDTH bits, im = lower WIDTH bits.
- Undefined: no LFSR logic is generated and mode 3 behaves as ramp.

Decomposition:
- Package alpaca_types_pkg holds WIDTH, SAMP_PER_CLK, cx_t (packed re/im, im in the upper half), packed pkt_t (cx_t [SAMP_PER_CLK-1:0]), and the mode_t enum (MODE_RAMP, MODE_IMPULSE, MODE_CONST, MODE_NOISE).
- The module parameters default to the package values.
- One sub-module, pattern_lane: combinational per-lane sample generator taking mode_q, sample index n, and the LFSR state. It is instantiated SAMP_PER_CLK times in a generate loop.

Test Plan:
- Ramp, FFT_LEN=16, SPC=4, tready=1, en=1 for 2 frames then 0: beats {0,1,2,3}..{12,13,14,15} repeat. tlast on beats 3 and 7; frame_cnt=2; done pulses once; tvalid low afterwards.
- Impulse, IMPULSE_PHA=3, IMPULSE_VAL=16: beat 0 = {0,0,0,16} (lane 3), all other beats zero. Repeat with PHA=13: beat 3 lane 1 = 16.
- Backpressure, random tready (50%): tdata and tlast stable whenever tvalid&!tready. Captured stream equals the ideal ramp sequence with no gaps or duplicates.
- Mode switch mid-frame (ramp to constant at beat 1): frame finishes as ramp, next frame is all 16s. en dropped at beat 2: frame completes through tlast, then IDLE.
- NUM_FRAMES=3, en held high: exactly 12 beats, done at the cycle after the third tlast, restart after IDLE. rst_n pulsed low mid-frame: tvalid and frame_cnt are 0 immediately (asynchronously).
- PATTERN_NOISE_EN, mode 3: lane LFSR outputs match a reference model for 64 beats; no repeats within the period.

Source files
------------

// File: rtl/alpaca_types_pkg.sv
// Shared sample/packet types, mode and FSM encodings, and LFSR tap table
// for the AXI4-Stream pattern generator.
package alpaca_types_pkg;

  localparam int WIDTH        = 16;
  localparam int SAMP_PER_CLK = 4;

  typedef struct packed {
    logic signed [WIDTH-1:0] im;
    logic signed [WIDTH-1:0] re;
  } cx_t;

  typedef cx_t [SAMP_PER_CLK-1:0] pkt_t;

  typedef enum logic [1:0] {
    MODE_RAMP    = 2'd0,
    MODE_IMPULSE = 2'd1,
    MODE_CONST   = 2'd2,
    MODE_NOISE   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  // Maximal-length Fibonacci tap masks (bit k-1 set for tap k).
  function automatic logic [63:0] lfsr_taps(input int unsigned len);
    case (len)
      8:       return 64'h0000_0000_0000_00B8;
      16:      return 64'h0000_0000_0000_D008;
      64:      return 64'hD800_0000_0000_0000;
      default: return 64'h0000_0000_8020_0003;
    endcase
  endfunction

endpackage

// File: rtl/pattern_lane.sv
// One lane of the pattern generator: maps mode and sample index to a {im,re} sample.
// Purely combinational; optional PATTERN_NOISE_EN adds the LFSR noise input.
module pattern_lane
  import alpaca_types_pkg::*;
#(
  parameter int LANE_W      = 16,
  parameter int N_W         = 4,
  parameter int IMPULSE_PHA = 0,
  parameter int IMPULSE_VAL = 1
) (
  input  mode_t               mode,
  input  logic [N_W-1:0]      n,
`ifdef PATTERN_NOISE_EN
  input  logic [2*LANE_W-1:0] lfsr,
`endif
  output logic [2*LANE_W-1:0] sample
);

  logic [LANE_W-1:0] re;
  logic [LANE_W-1:0] im;

  always_comb begin
    re = '0;
    im = '0;
    case (mode)
      MODE_IMPULSE: re = (n == N_W'(IMPULSE_PHA)) ? LANE_W'(IMPULSE_VAL) : '0;
      MODE_CONST:   re = LANE_W'(IMPULSE_VAL);
`ifdef PATTERN_NOISE_EN
      MODE_NOISE: begin
        re = lfsr[2*LANE_W-1:LANE_W];
        im = lfsr[LANE_W-1:0];
      end
`endif
      default:      re = LANE_W'(n);
    endcase
  end

  assign sample = {im, re};

endmodule

// File: rtl/axis_pattern_generator.sv
// AXI4-Stream test-pattern source (ramp/impulse/constant, noise with PATTERN_NOISE_EN); registered outputs, one beat per clock.
// A beat is held while tvalid & !tready; frames always complete with tlast before a stop takes effect.
module axis_pattern_generator #(
  parameter int WIDTH        = alpaca_types_pkg::WIDTH,
  parameter int SAMP_PER_CLK = alpaca_types_pkg::SAMP_PER_CLK,
  parameter int FFT_LEN      = 16,
  parameter int IMPULSE_PHA  = 0,
  parameter int IMPULSE_VAL  = 1,
  parameter int NUM_FRAMES   = 0,
  parameter int CNT_W        = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [1:0]                      mode,
  input  logic                            m_axis_tready,
  output logic [SAMP_PER_CLK*2*WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  output logic [CNT_W-1:0]                frame_cnt,
  output logic                            busy,
  output logic                            done
);
  import alpaca_types_pkg::*;

  localparam int BEATS  = FFT_LEN / SAMP_PER_CLK;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int N_W    = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
  localparam int LW     = 2 * WIDTH;
  localparam int DW     = SAMP_PER_CLK * LW;
  localparam logic [BEAT_W-1:0] LAST_BEAT    = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  NUM_FRAMES_C = CNT_W'(NUM_FRAMES);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  mode_t             mode_q, mode_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [DW-1:0]     tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              done_q, done_d;
  logic              busy_q;
  logic              load;
  logic              hs;
  logic              last_run_frame;
  logic [DW-1:0]     beat_dat;

`ifdef PATTERN_NOISE_EN
  localparam logic [LW-1:0] TAPS = LW'(lfsr_taps(LW));
  logic [LW-1:0] lfsr_q [SAMP_PER_CLK];
  logic [LW-1:0] lfsr_d [SAMP_PER_CLK];
`endif

  assign hs             = tvalid_q & m_axis_tready;
  assign last_run_frame = (NUM_FRAMES != 0) && ((frame_cnt_q + CNT_W'(1)) == NUM_FRAMES_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // STOP is RUN with a stop pending; the decision is taken only at the tlast handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN, ST_STOP: begin
        if (hs && tlast_q && (last_run_frame || !en)) state_d = ST_IDLE;
        else                                          state_d = en ? ST_RUN : ST_STOP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    beat_d      = beat_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    tvalid_d    = tvalid_q;
    done_d      = 1'b0;
    load        = 1'b0;
`ifdef PATTERN_NOISE_EN
    for (int j = 0; j < SAMP_PER_CLK; j++) lfsr_d[j] = lfsr_q[j];
`endif
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          mode_d      = mode_t'(mode);
          frame_cnt_d = '0;
          beat_d      = '0;
          tvalid_d    = 1'b1;
          load        = 1'b1;
`ifdef PATTERN_NOISE_EN
          for (int j = 0; j < SAMP_PER_CLK; j++) lfsr_d[j] = LW'(j + 1);
`endif
        end
      end
      default: begin
        if (hs) begin
`ifdef PATTERN_NOISE_EN
          for (int j = 0; j < SAMP_PER_CLK; j++)
            lfsr_d[j] = {lfsr_q[j][LW-2:0], ^(lfsr_q[j] & TAPS)};
`endif
          if (tlast_q) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            beat_d      = '0;
            mode_d      = mode_t'(mode);
            if (state_d == ST_IDLE) begin
              tvalid_d = 1'b0;
              done_d   = 1'b1;
            end else begin
              load = 1'b1;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
            load   = 1'b1;
          end
        end
      end
    endcase
    tdata_d = load ? beat_dat : tdata_q;
    tlast_d = tvalid_d && (beat_d == LAST_BEAT);
  end

  // Lanes always look at the next beat/mode so new data lands in the handshake cycle.
  for (genvar j = 0; j < SAMP_PER_CLK; j++) begin : g_lane
    logic [N_W-1:0] lane_n;
    assign lane_n = N_W'(32'(beat_d) * SAMP_PER_CLK + j);

    pattern_lane #(
      .LANE_W      (WIDTH),
      .N_W         (N_W),
      .IMPULSE_PHA (IMPULSE_PHA),
      .IMPULSE_VAL (IMPULSE_VAL)
    ) u_lane (
      .mode   (mode_d),
      .n      (lane_n),
`ifdef PATTERN_NOISE_EN
      .lfsr   (lfsr_d[j]),
`endif
      .sample (beat_dat[j*LW +: LW])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q      <= '0;
      mode_q      <= MODE_RAMP;
      frame_cnt_q <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PATTERN_NOISE_EN
      for (int j = 0; j < SAMP_PER_CLK; j++) lfsr_q[j] <= '0;
`endif
    end else begin
      beat_q      <= beat_d;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      done_q      <= done_d;
      busy_q      <= (state_d != ST_IDLE);
`ifdef PATTERN_NOISE_EN
      for (int j = 0; j < SAMP_PER_CLK; j++) lfsr_q[j] <= lfsr_d[j];
`endif
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign frame_cnt     = frame_cnt_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_axis_pattern_generator.sv
// Directed bench for axis_pattern_generator: two instances (continuous run / NUM_FRAMES=3).
module tb_axis_pattern_generator;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en_a, en_b, rdy;
  logic [1:0]   mode;
  logic [127:0] tdata_a, tdata_b;
  logic         tvalid_a, tvalid_b, tlast_a, tlast_b;
  logic [15:0]  fcnt_a, fcnt_b;
  logic         busy_a, busy_b, done_a, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axis_pattern_generator #(
    .WIDTH(16), .SAMP_PER_CLK(4), .FFT_LEN(16), .IMPULSE_PHA(3),
    .IMPULSE_VAL(16), .NUM_FRAMES(0), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode), .m_axis_tready(rdy),
    .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tlast(tlast_a),
    .frame_cnt(fcnt_a), .busy(busy_a), .done(done_a)
  );

  axis_pattern_generator #(
    .WIDTH(16), .SAMP_PER_CLK(4), .FFT_LEN(16), .IMPULSE_PHA(13),
    .IMPULSE_VAL(16), .NUM_FRAMES(3), .CNT_W(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode), .m_axis_tready(rdy),
    .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tlast(tlast_b),
    .frame_cnt(fcnt_b), .busy(busy_b), .done(done_b)
  );

  // Expected beat: lane j carries sample n = 4*b + j, re in the low half, im = 0.
  function automatic logic [127:0] model(input int m, input int b, input int pha);
    logic [127:0] r;
    logic [15:0]  re;
    int           n;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      n  = 4 * b + j;
      re = (m == 1) ? ((n == pha) ? 16'd16 : 16'd0) : (m == 2) ? 16'd16 : 16'(n);
      r[32*j +: 16] = re;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat_a(input string tag, input int m, input int b, input int pha);
    check({tag, "_vld"},  128'(tvalid_a), 128'(1));
    check({tag, "_dat"},  tdata_a, model(m, b, pha));
    check({tag, "_last"}, 128'(tlast_a), 128'(b == 3));
  endtask

  task automatic check_beat_b(input string tag, input int m, input int b, input int pha);
    check({tag, "_vld"},  128'(tvalid_b), 128'(1));
    check({tag, "_dat"},  tdata_b, model(m, b, pha));
    check({tag, "_last"}, 128'(tlast_b), 128'(b == 3));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cyc, beats;
    logic hs;
`ifdef PATTERN_NOISE_EN
    logic [31:0] s [4];
    logic [31:0] hist [64];
    logic [127:0] exp_n;
    int dup;
`endif

    rst_n = 1'b1; en_a = 1'b0; en_b = 1'b0; mode = 2'd0; rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_tvalid", 128'(tvalid_a), 128'(0));
    check("rst_tlast",  128'(tlast_a),  128'(0));
    check("rst_tdata",  tdata_a,        128'(0));
    check("rst_fcnt",   128'(fcnt_a),   128'(0));
    check("rst_busy",   128'(busy_a),   128'(0));
    check("rst_done",   128'(done_a),   128'(0));
    step(); step();
    rst_n = 1'b1;
    step();
    check("idle_tvalid", 128'(tvalid_a), 128'(0));

    // Ramp, two frames at full rate, en dropped during the second frame.
    mode = 2'd0; rdy = 1'b1; en_a = 1'b1;
    step();
    check("ramp_busy", 128'(busy_a), 128'(1));
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 4; b++) begin
        check_beat_a("ramp", 0, b, 3);
        if (b == 0) check("ramp_fcnt", 128'(fcnt_a), 128'(f));
        if (f == 1 && b == 3) en_a = 1'b0;
        step();
      end
    end
    check("ramp_end_vld",  128'(tvalid_a), 128'(0));
    check("ramp_end_done", 128'(done_a),   128'(1));
    check("ramp_end_fcnt", 128'(fcnt_a),   128'(2));
    check("ramp_end_busy", 128'(busy_a),   128'(0));
    step();
    check("ramp_done_pulse", 128'(done_a),   128'(0));
    check("ramp_idle_vld",   128'(tvalid_a), 128'(0));

    // Random backpressure: the held beat must always match the next ideal ramp sample.
    en_a = 1'b1; idx = 0; cyc = 0;
    while (idx < 8 && cyc < 300) begin
      if (tvalid_a) begin
        check("bp_dat",  tdata_a,        model(0, idx % 4, 3));
        check("bp_last", 128'(tlast_a),  128'((idx % 4) == 3));
      end
      if (idx >= 4) en_a = 1'b0;
      rdy = 1'($urandom_range(0, 1));
      hs  = tvalid_a && rdy;
      step();
      if (hs) idx++;
      cyc++;
    end
    check("bp_count", 128'(idx),      128'(8));
    check("bp_vld",   128'(tvalid_a), 128'(0));
    check("bp_done",  128'(done_a),   128'(1));
    check("bp_fcnt",  128'(fcnt_a),   128'(2));
    rdy = 1'b1;
    step();

    // Impulse at sample 3: only lane 3 of beat 0 carries 16.
    mode = 2'd1; en_a = 1'b1;
    step();
    check("imp_lit", tdata_a, 128'h00000010_00000000_00000000_00000000);
    for (int b = 0; b < 4; b++) begin
      check_beat_a("imp", 1, b, 3);
      if (b == 3) en_a = 1'b0;
      step();
    end
    check("imp_end_vld", 128'(tvalid_a), 128'(0));
    step();

    // Mode switch mid-frame takes effect at the frame boundary; en drop mid-frame completes it.
    mode = 2'd0; en_a = 1'b1;
    step();
    for (int b = 0; b < 4; b++) begin
      check_beat_a("sw_ramp", 0, b, 3);
      if (b == 1) mode = 2'd2;
      step();
    end
    for (int b = 0; b < 4; b++) begin
      check_beat_a("sw_const", 2, b, 3);
      if (b == 2) en_a = 1'b0;
      step();
    end
    check("sw_end_vld",  128'(tvalid_a), 128'(0));
    check("sw_end_done", 128'(done_a),   128'(1));
    check("sw_end_fcnt", 128'(fcnt_a),   128'(2));
    step();

    // NUM_FRAMES=3 with en held high, impulse at sample 13 (beat 3, lane 1).
    mode = 2'd1; en_b = 1'b1;
    step();
    check("nf_b3_lit", model(1, 3, 13), 128'h00000000_00000000_00000010_00000000);
    beats = 0; cyc = 0;
    while (tvalid_b && cyc < 40) begin
      check_beat_b("nf", 1, beats % 4, 13);
      beats++; cyc++;
      step();
    end
    check("nf_beats", 128'(beats),    128'(12));
    check("nf_done",  128'(done_b),   128'(1));
    check("nf_vld",   128'(tvalid_b), 128'(0));
    check("nf_fcnt",  128'(fcnt_b),   128'(3));
    check("nf_busy",  128'(busy_b),   128'(0));
    step();
    check("nf_restart_done", 128'(done_b), 128'(0));
    check("nf_restart_fcnt", 128'(fcnt_b), 128'(0));
    check_beat_b("nf_restart", 1, 0, 13);
    for (int k = 0; k < 5; k++) step();
    check("nf_mid_fcnt", 128'(fcnt_b), 128'(1));
    check_beat_b("nf_mid", 1, 1, 13);

    // Asynchronous reset mid-frame, away from the clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("arst_vld",   128'(tvalid_b), 128'(0));
    check("arst_fcnt",  128'(fcnt_b),   128'(0));
    check("arst_tdata", tdata_b,        128'(0));
    check("arst_busy",  128'(busy_b),   128'(0));
    step();
    rst_n = 1'b1;
    en_b  = 1'b1;
    step();
    en_b = 1'b0;
    for (int b = 0; b < 4; b++) begin
      check_beat_b("post_rst", 1, b, 13);
      step();
    end
    check("post_rst_vld", 128'(tvalid_b), 128'(0));
    step();

`ifdef PATTERN_NOISE_EN
    // Noise: lane j seeded with j+1, taps 32,22,2,1, re = upper half, im = lower half.
    mode = 2'd3; en_a = 1'b1;
    for (int j = 0; j < 4; j++) s[j] = 32'(j + 1);
    step();
    for (int k = 0; k < 64; k++) begin
      exp_n = '0;
      for (int j = 0; j < 4; j++) exp_n[32*j +: 32] = {s[j][15:0], s[j][31:16]};
      check("noise_dat", tdata_a, exp_n);
      hist[k] = s[0];
      if (k == 63) en_a = 1'b0;
      step();
      for (int j = 0; j < 4; j++) s[j] = {s[j][30:0], s[j][31] ^ s[j][21] ^ s[j][1] ^ s[j][0]};
    end
    dup = 0;
    for (int a = 0; a < 64; a++)
      for (int c = a + 1; c < 64; c++)
        if (hist[a] == hist[c]) dup++;
    check("noise_unique", 128'(dup), 128'(0));
    check("noise_end_vld", 128'(tvalid_a), 128'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
